// File: rtl/reg_serializer_pkg.sv
// reg_serializer shared types: FSM state enum and counter width helper.
// REG_SERIALIZER_PARITY_EN adds the PARITY state.
package reg_serializer_pkg;

`ifdef REG_SERIALIZER_PARITY_EN
  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    PARITY
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE,
    SHIFT
  } state_t;
`endif

  // counter must hold SIZE-1; never narrower than one bit
  function automatic int cnt_w(input int size);
    return (size < 2) ? 1 : $clog2(size);
  endfunction

endpackage

// File: rtl/shift_reg.sv
// Loadable left-shifting data register for reg_serializer.
// Load wins over shift; msb is the bit currently on the wire.
module shift_reg #(
  parameter int SIZE = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ld,
  input  logic            sh,
  input  logic [SIZE-1:0] d,
  output logic            msb
);

  logic [SIZE-1:0] q;

  // load a new word or shift left, zero-filling the LSB
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (ld) begin
      q <= d;
    end else if (sh) begin
      q <= q << 1;
    end
  end

  assign msb = q[SIZE-1];

endmodule

// File: rtl/reg_serializer.sv
// MSB-first parallel-to-serial converter with valid/ready on both sides.
// Define REG_SERIALIZER_PARITY_EN to append an even-parity bit per frame.
module reg_serializer
  import reg_serializer_pkg::*;
#(
  parameter int SIZE = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [SIZE-1:0] in_data,
  output logic            ser_out,
  output logic            ser_valid,
  input  logic            ser_ready,
  output logic            ser_last
);

  localparam int CW = cnt_w(SIZE);

  state_t        state;
  state_t        nxt;
  logic [CW-1:0] cnt;
  logic          ld;
  logic          sh;
  logic          msb;

  shift_reg #(
    .SIZE(SIZE)
  ) u_sr (
    .clk(clk),
    .rst(rst),
    .ld (ld),
    .sh (sh),
    .d  (in_data),
    .msb(msb)
  );

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  // bits remaining after the current one
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (ld) begin
      cnt <= CW'(SIZE - 1);
    end else if (sh && cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

`ifdef REG_SERIALIZER_PARITY_EN
  logic par;

  // even parity captured with the word
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     par <= 1'b0;
    else if (ld) par <= ^in_data;
  end
`endif

  // next state, handshakes and serial outputs
  always_comb begin
    nxt       = state;
    in_ready  = 1'b0;
    ser_valid = 1'b0;
    ser_out   = 1'b0;
    ser_last  = 1'b0;
    ld        = 1'b0;
    sh        = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          ld  = 1'b1;
          nxt = SHIFT;
        end
      end
      SHIFT: begin
        ser_valid = 1'b1;
        ser_out   = msb;
`ifndef REG_SERIALIZER_PARITY_EN
        ser_last  = (cnt == '0);
`endif
        if (ser_ready) begin
          sh = 1'b1;
          if (cnt == '0) begin
`ifdef REG_SERIALIZER_PARITY_EN
            nxt = PARITY;
`else
            nxt = IDLE;
`endif
          end
        end
      end
`ifdef REG_SERIALIZER_PARITY_EN
      PARITY: begin
        ser_valid = 1'b1;
        ser_out   = par;
        ser_last  = 1'b1;
        if (ser_ready) nxt = IDLE;
      end
`endif
      default: nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_reg_serializer.sv
// Self-checking bench for reg_serializer: queue model, directed
// frames, async reset, SIZE=1 instance and random traffic.
module tb_reg_serializer;

`ifdef REG_SERIALIZER_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int NB = 8 + PB;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       ser_out;
  logic       ser_valid;
  logic       ser_ready;
  logic       ser_last;

  logic       v1;
  logic       r1;
  logic [0:0] d1;
  logic       o1;
  logic       sv1;
  logic       sl1;

  int checks = 0;
  int errs   = 0;
  int cyc    = 0;
  int vcyc   = 0;

  bit mq[$];
  bit got[$];
  bit lastq[$];
  int acc_t[$];

  always #5 clk = ~clk;

  reg_serializer #(.SIZE(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .ser_out  (ser_out),
    .ser_valid(ser_valid),
    .ser_ready(ser_ready),
    .ser_last (ser_last)
  );

  reg_serializer #(.SIZE(1)) dut1 (
    .clk      (clk),
    .rst      (rst),
    .in_valid (v1),
    .in_ready (r1),
    .in_data  (d1),
    .ser_out  (o1),
    .ser_valid(sv1),
    .ser_ready(1'b1),
    .ser_last (sl1)
  );

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s actual=%0h required=%0h", n, a, e);
    end
  endtask

  // model: a frame is just a queue of bits still owed downstream
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
    end else begin
      cyc++;
      if (mq.size() == 0) begin
        if (in_valid) begin
          for (int i = 7; i >= 0; i--) mq.push_back(in_data[i]);
          if (PB == 1) mq.push_back(^in_data);
          acc_t.push_back(cyc);
        end
      end else if (ser_ready) begin
        void'(mq.pop_front());
      end
    end
  end

  // compare every cycle against the model
  always @(negedge clk) begin
    chk("in_ready", in_ready, mq.size() == 0);
    chk("ser_valid", ser_valid, mq.size() != 0);
    chk("ser_out", ser_out, (mq.size() != 0) ? mq[0] : 1'b0);
    chk("ser_last", ser_last, mq.size() == 1);
  end

  // record bits as they are consumed
  always @(negedge clk) begin
    if (ser_valid) vcyc++;
    if (ser_valid && ser_ready) begin
      got.push_back(ser_out);
      lastq.push_back(ser_last);
    end
  end

  function automatic logic [7:0] byte_at(input int off);
    logic [7:0] v;
    v = '0;
    for (int i = 0; i < 8; i++)
      if (off + i < got.size()) v[7-i] = got[off+i];
    return v;
  endfunction

  task automatic clr();
    got.delete();
    lastq.delete();
    acc_t.delete();
    vcyc = 0;
  endtask

  task automatic send(input logic [7:0] w);
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = w;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_bits(input int n);
    int k;
    k = 0;
    while (got.size() < n && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("frame_bits", got.size(), n);
  endtask

  task automatic drain();
    repeat (NB + 4) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    ser_ready = 1'b1;
    v1 = 1'b0;
    d1 = '0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_ser_valid", ser_valid, 0);
    chk("rst_ser_out", ser_out, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // A5 with constant ready
    clr();
    send(8'hA5);
    wait_bits(NB);
    chk("a5_bits", byte_at(0), 8'hA5);
    chk("a5_vcyc", vcyc, NB);
    for (int i = 0; i < NB; i++)
      chk("a5_last", lastq[i], i == NB - 1);
    @(negedge clk);
    chk("a5_ready_after", in_ready, 1);
    drain();

    // 81 with a 3-cycle stall after the second bit
    clr();
    send(8'h81);
    wait_bits(2);
    @(posedge clk); #1;
    ser_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    ser_ready = 1'b1;
    wait_bits(NB);
    chk("81_bits", byte_at(0), 8'h81);
    chk("81_vcyc", vcyc, NB + 3);
    drain();

    // back-to-back with in_valid held
    clr();
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = 8'h3C;
    @(posedge clk); #1;
    in_data  = 8'hC3;
    for (int k = 0; k < 40 && acc_t.size() < 2; k++) begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    wait_bits(2 * NB);
    chk("b2b_first", byte_at(0), 8'h3C);
    chk("b2b_second", byte_at(NB), 8'hC3);
    chk("b2b_accepts", acc_t.size(), 2);
    if (acc_t.size() == 2)
      chk("b2b_gap", acc_t[1] - acc_t[0], NB + 1);
    drain();

    // async reset mid-frame
    clr();
    send(8'hFF);
    wait_bits(4);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("arst_valid", ser_valid, 0);
    chk("arst_out", ser_out, 0);
    chk("arst_last", ser_last, 0);
    chk("arst_ready", in_ready, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    clr();
    send(8'h01);
    wait_bits(NB);
    chk("after_rst_bits", byte_at(0), 8'h01);
    drain();

`ifdef REG_SERIALIZER_PARITY_EN
    // parity frame
    clr();
    send(8'h07);
    wait_bits(NB);
    chk("par_bits", byte_at(0), 8'h07);
    for (int i = 0; i < 8; i++) chk("par_dlast", lastq[i], 0);
    chk("par_bit", got[8], 1);
    chk("par_last", lastq[8], 1);
    drain();
`endif

    // SIZE=1 instance
    @(posedge clk); #1;
    v1 = 1'b1;
    d1 = 1'b1;
    @(posedge clk); #1;
    v1 = 1'b0;
    @(negedge clk);
    chk("s1_out", o1, 1);
    chk("s1_valid", sv1, 1);
    chk("s1_last", sl1, PB == 0);
    chk("s1_ready", r1, 0);
    if (PB == 1) begin
      @(negedge clk);
      chk("s1_par_out", o1, 1);
      chk("s1_par_last", sl1, 1);
    end
    @(negedge clk);
    chk("s1_idle_ready", r1, 1);
    chk("s1_idle_valid", sv1, 0);

    // random traffic
    clr();
    for (int k = 0; k < 400; k++) begin
      @(posedge clk); #1;
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = 8'($urandom);
      ser_ready = ($urandom_range(0, 9) < 7);
    end
    in_valid  = 1'b0;
    ser_ready = 1'b1;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, errs);
    $finish;
  end

endmodule

// File: doc/reg_serializer.md
REG_SERIALIZER -- requirements
Module: reg_serializer

Interface
REQ-001 SHALL have parameter: SIZE, default 8, width of the parallel word (SIZE >= 1).
REQ-002 SHALL have port: clk  input  1  rising-edge clock.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: in_valid  input  1  parallel word offered.
REQ-005 SHALL have port: in_ready  output  1  block can accept a word.
REQ-006 SHALL have port: in_data  input  SIZE  parallel word.
REQ-007 SHALL have port: ser_out  output  1  current serial bit.
REQ-008 SHALL have port: ser_valid  output  1  ser_out holds a valid bit.
REQ-009 SHALL have port: ser_ready  input  1  downstream consumes ser_out this cycle.
REQ-010 SHALL have port: ser_last  output  1  current bit is the final bit of the frame.

Function
REQ-011 SHALL implement states IDLE and SHIFT, plus PARITY when REQ-024 applies.
REQ-012 SHALL drive in_ready=1 only in IDLE; in SHIFT and PARITY, in_ready=0.
REQ-013 SHALL, on a clk edge with in_valid&in_ready, load in_data into the shift register, set the bit counter to SIZE-1, and enter SHIFT.
REQ-014 SHALL ignore in_data whenever in_ready=0; no word is lost or queued.
REQ-015 SHALL, in SHIFT, drive ser_valid=1 and ser_out=shift-register MSB (MSB-first order).
REQ-016 SHALL, on an edge with ser_valid&ser_ready in SHIFT, shift left by one and decrement the counter.
REQ-017 SHALL hold ser_out, the counter and the state unchanged while ser_ready=0 (stall), for any number of cycles.
REQ-018 SHALL assert ser_last combinationally in SHIFT when counter==0 and PARITY_EN is undefined; ser_last SHALL be 0 otherwise in SHIFT.
REQ-019 SHALL, on the handshake of the counter==0 bit, go to IDLE (PARITY_EN undefined) or PARITY (PARITY_EN defined).
REQ-020 SHALL give one frame of SIZE bits for SIZE=1, with ser_last asserted on the first and only bit.
REQ-021 SHALL have minimum frame latency of 1 cycle (accept edge -> first bit valid next cycle); back-to-back frames SHALL be separated by exactly one IDLE cycle.
REQ-022 SHALL drive ser_valid=0, ser_last=0 and ser_out=0 in IDLE.

Reset
REQ-023 SHALL, while rst=1 in any state, including mid-frame, force IDLE, in_ready=1, ser_valid=0, ser_last=0, ser_out=0, shift register=0 and counter=0; any partial frame SHALL be abandoned without completion.

Configuration
REQ-024 SHALL, with macro REG_SERIALIZER_PARITY_EN defined, append one even-parity bit (XOR of the loaded word) after the data bits. In PARITY: ser_valid=1, ser_out=parity, ser_last=1, and the state returns to IDLE on ser_ready. Without the macro: there is no PARITY state, no parity logic, and the frame is SIZE bits.
REQ-025 SHALL compute parity at load time from in_data and hold it in a 1-bit register.

Structure
REQ-026 SHALL place the state enum typedef and the counter-width constant/function (clog2 of SIZE, minimum 1) in shared package reg_serializer_pkg.
REQ-027 SHALL isolate the loadable, left-shifting datapath register in one sub-module, shift_reg (ports clk, rst, ld, sh, d, msb).

Verification
REQ-028 SHALL have the bench cover: SIZE=8, in_data=8'hA5, ser_ready=1 always -> ser_out 1,0,1,0,0,1,0,1 on consecutive cycles, with ser_last on the 8th bit and in_ready=1 the following cycle.
REQ-029 SHALL have the bench cover: 8'h81 with ser_ready low for 3 cycles after the 2nd bit -> bit 2 (0) held for 4 cycles, total frame 11 cycles, bit order intact.
REQ-030 SHALL have the bench cover: in_valid held high with 8'h3C then 8'hC3 -> first word serialized, 1 IDLE cycle, then second word; in_data changes during SHIFT are ignored.
REQ-031 SHALL have the bench cover: rst pulsed asynchronously after the 4th bit of 8'hFF -> outputs zero immediately, IDLE, and the next word 8'h01 serializes cleanly.
REQ-032 SHALL have the bench cover: SIZE=1, in_data=1 -> a single bit 1 with ser_last=1, then IDLE.
REQ-033 SHALL have the bench cover: REG_SERIALIZER_PARITY_EN defined, 8'h07 -> 8 data bits, ser_last=0 on all of them, then parity bit 1 with ser_last=1.
